// File: rtl/pupil_centroid.sv
// Dark-pixel centroid and bounding box over a raster-scanned frame.
// Sums are divided by the dark count with a serial 25-step restoring divider.
module pupil_centroid #(
    parameter int unsigned IMG_W     = 320,
    parameter int unsigned IMG_H     = 240,
    parameter logic [7:0]  THRESH    = 8'd40,
    parameter int unsigned MIN_COUNT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [19:0] pix_addr,
    input  logic [7:0]  pix_data,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [8:0]  cx,
    output logic [7:0]  cy,
    output logic [8:0]  min_x,
    output logic [8:0]  max_x,
    output logic [7:0]  min_y,
    output logic [7:0]  max_y,
    output logic [16:0] dark_count,
    output logic        seq_err,
    output logic        drop_err
);

    localparam logic [8:0]  LastCol  = 9'(IMG_W - 1);
    localparam logic [7:0]  LastRow  = 8'(IMG_H - 1);
    localparam logic [16:0] MinCnt   = 17'(MIN_COUNT);
    localparam logic [4:0]  LastIter = 5'd24;

    typedef enum logic [1:0] {StAccum, StDivX, StDivY, StDone} state_e;

    state_e state_q, state_d;

    logic [8:0]  col_q;
    logic [7:0]  row_q;
    logic [19:0] exp_idx_q;
    logic [16:0] cnt_q;
    logic [24:0] sum_x_q, sum_y_q;
    logic [8:0]  bb_min_x_q, bb_max_x_q;
    logic [7:0]  bb_min_y_q, bb_max_y_q;
    logic [24:0] quo_q;
    logic [16:0] rem_q;
    logic [4:0]  iter_q;
    logic [8:0]  cx_res_q;
    logic [7:0]  cy_res_q;

    logic        sample, dark, acc_upd, last_col, last_pix, frame_end, iter_last;
    logic [16:0] cnt_d;
    logic [24:0] sum_x_d;
    logic [17:0] rem_sh, rem_nx;
    logic        rem_ge;
    logic [24:0] quo_nx;

    assign busy      = (state_q != StAccum);
    assign sample    = pix_valid && (state_q == StAccum);
    assign dark      = (pix_data < THRESH);
    assign acc_upd   = sample && dark;
    assign last_col  = (col_q == LastCol);
    assign last_pix  = last_col && (row_q == LastRow);
    assign frame_end = sample && last_pix;
    assign iter_last = (iter_q == LastIter);
    assign cnt_d     = acc_upd ? cnt_q + 17'd1 : cnt_q;
    assign sum_x_d   = acc_upd ? sum_x_q + 25'(col_q) : sum_x_q;

    // One restoring step: dividend bits shift out of quo_q into the remainder.
    assign rem_sh = {rem_q, quo_q[24]};
    assign rem_ge = (rem_sh >= {1'b0, cnt_q});
    assign rem_nx = rem_ge ? rem_sh - {1'b0, cnt_q} : rem_sh;
    assign quo_nx = {quo_q[23:0], rem_ge};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (frame_end) state_d = (cnt_d >= MinCnt) ? StDivX : StDone;
            StDivX:  if (iter_last) state_d = StDivY;
            StDivY:  if (iter_last) state_d = StDone;
            StDone:  state_d = StAccum;
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= StAccum;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q      <= '0;
            row_q      <= '0;
            exp_idx_q  <= '0;
            cnt_q      <= '0;
            sum_x_q    <= '0;
            sum_y_q    <= '0;
            bb_min_x_q <= 9'd511;
            bb_max_x_q <= '0;
            bb_min_y_q <= 8'd255;
            bb_max_y_q <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            iter_q     <= '0;
            cx_res_q   <= '0;
            cy_res_q   <= '0;
            done       <= 1'b0;
            found      <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            min_x      <= '0;
            max_x      <= '0;
            min_y      <= '0;
            max_y      <= '0;
            dark_count <= '0;
            seq_err    <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pix_valid && busy) drop_err <= 1'b1;

            if (sample) begin
                if (pix_addr != exp_idx_q) seq_err <= 1'b1;
                if (last_pix) begin
                    col_q     <= '0;
                    row_q     <= '0;
                    exp_idx_q <= '0;
                end else begin
                    exp_idx_q <= exp_idx_q + 20'd1;
                    if (last_col) begin
                        col_q <= '0;
                        row_q <= row_q + 8'd1;
                    end else begin
                        col_q <= col_q + 9'd1;
                    end
                end
                cnt_q   <= cnt_d;
                sum_x_q <= sum_x_d;
                if (acc_upd) begin
                    sum_y_q <= sum_y_q + 25'(row_q);
                    if (col_q < bb_min_x_q) bb_min_x_q <= col_q;
                    if (col_q > bb_max_x_q) bb_max_x_q <= col_q;
                    if (row_q < bb_min_y_q) bb_min_y_q <= row_q;
                    if (row_q > bb_max_y_q) bb_max_y_q <= row_q;
                end
                if (frame_end) begin
                    quo_q  <= sum_x_d;
                    rem_q  <= '0;
                    iter_q <= '0;
                end
            end

            unique case (state_q)
                StDivX, StDivY: begin
                    rem_q  <= rem_nx[16:0];
                    quo_q  <= quo_nx;
                    iter_q <= iter_q + 5'd1;
                    if (iter_last) begin
                        iter_q <= '0;
                        rem_q  <= '0;
                        if (state_q == StDivX) begin
                            cx_res_q <= quo_nx[8:0];
                            quo_q    <= sum_y_q;
                        end else begin
                            cy_res_q <= quo_nx[7:0];
                        end
                    end
                end
                StDone: begin
                    done       <= 1'b1;
                    dark_count <= cnt_q;
                    if (cnt_q >= MinCnt) begin
                        found <= 1'b1;
                        cx    <= cx_res_q;
                        cy    <= cy_res_q;
                        min_x <= bb_min_x_q;
                        max_x <= bb_max_x_q;
                        min_y <= bb_min_y_q;
                        max_y <= bb_max_y_q;
                    end else begin
                        found <= 1'b0;
                        cx    <= '0;
                        cy    <= '0;
                        min_x <= '0;
                        max_x <= '0;
                        min_y <= '0;
                        max_y <= '0;
                    end
                    cnt_q      <= '0;
                    sum_x_q    <= '0;
                    sum_y_q    <= '0;
                    bb_min_x_q <= 9'd511;
                    bb_max_x_q <= '0;
                    bb_min_y_q <= 8'd255;
                    bb_max_y_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pupil_centroid.sv
// Directed bench for pupil_centroid on a reduced 64x48 frame.
// Latency N means done is high when sampled by the Nth rising edge after the last pixel.
module tb_pupil_centroid;

    localparam int W = 64;
    localparam int H = 48;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic [19:0] pix_addr = '0;
    logic [7:0]  pix_data = '0;
    logic        busy, done, found, seq_err, drop_err;
    logic [8:0]  cx, min_x, max_x;
    logic [7:0]  cy, min_y, max_y;
    logic [16:0] dark_count;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pupil_centroid #(.IMG_W(W), .IMG_H(H), .THRESH(8'd40), .MIN_COUNT(16)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_addr(pix_addr),
        .pix_data(pix_data), .busy(busy), .done(done), .found(found), .cx(cx), .cy(cy),
        .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
        .dark_count(dark_count), .seq_err(seq_err), .drop_err(drop_err)
    );

    typedef struct {
        int kind;   // 0 all FF, 1 10x10 block, 2 all 00, 3 15 dark, 4 16 dark
        int skip;   // address index that gets skipped, -1 for none
        bit pulse;  // pix_valid pulse while dividing
        int lat;
        int found, cnt, cx, cy, minx, maxx, miny, maxy, seq, drop;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int kind, input int x, input int y,
                                           input int idx);
        case (kind)
            0: return 8'hFF;
            1: return (x >= 20 && x <= 29 && y >= 10 && y <= 19) ? 8'h10 : 8'hFF;
            2: return 8'h00;
            3: return (idx < 15) ? 8'd39 : 8'd40;
            default: return (idx < 16) ? 8'd39 : 8'd40;
        endcase
    endfunction

    task automatic send_frame(input int kind, input int skip);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_addr  = 20'((skip >= 0 && i >= skip) ? i + 1 : i);
            pix_data  = pix_val(kind, i % W, i / W, i);
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    // Called at the first negedge after the last-pixel edge; returns latency or -1.
    task automatic wait_done(input bit pulse, input int busy_exp, output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 3) check("busy_mid", int'(busy), busy_exp);
            pix_valid = (pulse && k == 5);
            if (done) begin
                lat = k;
                break;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic check_results(input vec_t v, input string tag);
        check({tag, "_found"}, int'(found), v.found);
        check({tag, "_cnt"}, int'(dark_count), v.cnt);
        check({tag, "_cx"}, int'(cx), v.cx);
        check({tag, "_cy"}, int'(cy), v.cy);
        check({tag, "_minx"}, int'(min_x), v.minx);
        check({tag, "_maxx"}, int'(max_x), v.maxx);
        check({tag, "_miny"}, int'(min_y), v.miny);
        check({tag, "_maxy"}, int'(max_y), v.maxy);
        check({tag, "_seq"}, int'(seq_err), v.seq);
        check({tag, "_drop"}, int'(drop_err), v.drop);
    endtask

    vec_t vecs[7];
    vec_t blk;
    int   lat;
    int   ndone;

    initial begin
        vecs[0] = '{0, -1, 0,  2, 0,    0,  0,  0,  0,  0,  0,  0, 0, 0};
        vecs[1] = '{1, -1, 0, 52, 1,  100, 24, 14, 20, 29, 10, 19, 0, 0};
        vecs[2] = '{2, -1, 0, 52, 1, 3072, 31, 23,  0, 63,  0, 47, 0, 0};
        vecs[3] = '{3, -1, 0,  2, 0,   15,  0,  0,  0,  0,  0,  0, 0, 0};
        vecs[4] = '{4, -1, 0, 52, 1,   16,  7,  0,  0, 15,  0,  0, 0, 0};
        vecs[5] = '{1, 500, 0, 52, 1, 100, 24, 14, 20, 29, 10, 19, 1, 0};
        vecs[6] = '{1, -1, 1, 52, 1,  100, 24, 14, 20, 29, 10, 19, 1, 1};
        blk = vecs[1];

        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check_results('{0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, "rst");

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].kind, vecs[v].skip);
            wait_done(vecs[v].pulse, (vecs[v].lat == 52) ? 1 : 0, lat);
            check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            if (lat > 0) check_results(vecs[v], $sformatf("v%0d", v));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", v), int'(done), 0);
            check($sformatf("v%0d_hold_cx", v), int'(cx), vecs[v].cx);
        end

        // Abort a frame 10 cycles into DIV_Y.
        send_frame(1, -1);
        for (int k = 2; k <= 36; k++) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check_results('{0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, "abort");
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        send_frame(1, -1);
        wait_done(1'b0, 1, lat);
        check("post_abort_latency", lat, 52);
        if (lat > 0) check_results(blk, "post_abort");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
